// File: rtl/steer_pkg.sv
// Shared types and constants for the four-destination steering arbiter.
package steer_pkg;

  localparam int NDST = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEER = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [NDST-1:0] STEER_NULL = 4'b0000;
  localparam logic [NDST-1:0] STEER_S    = 4'b0001;
  localparam logic [NDST-1:0] STEER_T    = 4'b0010;
  localparam logic [NDST-1:0] STEER_U    = 4'b0100;
  localparam logic [NDST-1:0] STEER_V    = 4'b1000;

  function automatic logic [NDST-1:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    onehot = STEER_S;
      2'd1:    onehot = STEER_T;
      2'd2:    onehot = STEER_U;
      default: onehot = STEER_V;
    endcase
  endfunction

endpackage

// File: rtl/steer_arb4_rr_pick4.sv
// Rotating-priority pick over four destinations, starting at ptr; purely combinational.
module rr_pick4
  import steer_pkg::*;
(
  input  logic [1:0]      ptr,
  input  logic [NDST-1:0] mask,
  input  logic [NDST-1:0] rdy,
  input  logic            mode,
  output logic [1:0]      sel,
  output logic            valid
);

  logic [1:0] w_idx;
  logic       w_found_m;
  logic       w_found_r;

  // The first masked slot is always the candidate; mode 1 moves on to the first ready one.
  always_comb begin
    sel       = ptr;
    valid     = 1'b0;
    w_idx     = ptr;
    w_found_m = 1'b0;
    w_found_r = 1'b0;
    for (int k = 0; k < NDST; k++) begin
      w_idx = ptr + 2'(k);
      if (mask[w_idx]) begin
        if (!w_found_m) begin
          w_found_m = 1'b1;
          sel       = w_idx;
          valid     = rdy[w_idx];
        end
        if (mode && rdy[w_idx] && !w_found_r) begin
          w_found_r = 1'b1;
          sel       = w_idx;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/steer_arb4.sv
// Four-phase steering arbiter: routes complete input words to one of four
// destination buffers in rotating order and acknowledges the input side.
//
//   state | meaning
//   IDLE  | choosing next destination, waiting for a complete input word
//   STEER | word steered to cur_dst, waiting for that buffer to complete
//   ACK   | steer_done raised, waiting for the input NULL wavefront
//   DRAIN | steer released, waiting for the destination buffer to go NULL
module steer_arb4
  import steer_pkg::*;
(
  input  logic            clk,
  input  logic            init_n,
  input  logic            in_comp,
  input  logic [NDST-1:0] dst_rdy,
  input  logic [NDST-1:0] dst_comp,
  input  logic [NDST-1:0] dst_mask,
  input  logic            mode,
  output logic [NDST-1:0] steer,
  output logic            steer_done,
  output logic [1:0]      cur_dst,
  output logic            busy,
  output logic [15:0]     word_cnt,
  output logic            err
);

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [1:0]      r_cur, w_cur_nxt;
  logic [NDST-1:0] r_steer, w_steer_nxt;
  logic            r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_err, w_err_nxt;
  logic [15:0]     r_word_cnt, w_cnt_nxt;
  logic [1:0]      w_sel;
  logic            w_valid;
  logic [NDST-1:0] w_other;

  rr_pick4 u_pick (
    .ptr   (r_ptr),
    .mask  (dst_mask),
    .rdy   (dst_rdy),
    .mode  (mode),
    .sel   (w_sel),
    .valid (w_valid)
  );

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_cur      <= 2'd0;
      r_steer    <= STEER_NULL;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_word_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cur      <= w_cur_nxt;
      r_steer    <= w_steer_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_word_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cur_nxt   = r_cur;
    w_steer_nxt = r_steer;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_word_cnt;
    w_other     = dst_comp & ~onehot(r_cur);
    case (r_state)
      IDLE: begin
        // Mask/mode are only sampled here, so mid-word changes cannot redirect a word.
        w_cur_nxt = w_sel;
        if (in_comp && w_valid) begin
          w_state_nxt = STEER;
          w_steer_nxt = onehot(w_sel);
        end
      end
      STEER: begin
        if (|w_other) w_err_nxt = 1'b1;
        if (!in_comp) begin
          w_err_nxt = 1'b1;
        end else if (dst_comp[r_cur]) begin
          w_state_nxt = ACK;
          w_done_nxt  = 1'b1;
        end
      end
      ACK: begin
        if (|w_other) w_err_nxt = 1'b1;
        if (!in_comp) begin
          w_state_nxt = DRAIN;
          w_steer_nxt = STEER_NULL;
        end
      end
      DRAIN: begin
        if (!dst_comp[r_cur]) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b0;
          w_ptr_nxt   = r_cur + 2'd1;
          w_cnt_nxt   = r_word_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_steer_nxt = STEER_NULL;
        w_done_nxt  = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign steer      = r_steer;
  assign steer_done = r_done;
  assign cur_dst    = r_cur;
  assign busy       = r_busy;
  assign word_cnt   = r_word_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_steer_arb4.sv
// Self-checking bench for steer_arb4: vector table plus handshake corner sequences.
module tb_steer_arb4;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic        in_comp = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  dst_rdy = 4'b0000;
  logic [3:0]  dst_comp = 4'b0000;
  logic [3:0]  dst_mask = 4'b0000;
  logic [3:0]  steer;
  logic        steer_done;
  logic [1:0]  cur_dst;
  logic        busy;
  logic [15:0] word_cnt;
  logic        err;

  steer_arb4 dut (
    .clk        (clk),
    .init_n     (init_n),
    .in_comp    (in_comp),
    .dst_rdy    (dst_rdy),
    .dst_comp   (dst_comp),
    .dst_mask   (dst_mask),
    .mode       (mode),
    .steer      (steer),
    .steer_done (steer_done),
    .cur_dst    (cur_dst),
    .busy       (busy),
    .word_cnt   (word_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic       md;
    logic [3:0] rdy;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[16];
  logic [3:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // which: 0 = steer nonzero, 1 = steer_done, other = busy
  task automatic wait_sig(input int which, input logic val, input string name, inout int n);
    int   k;
    logic cur;
    k   = 0;
    cur = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      k++;
      case (which)
        0:       cur = |steer;
        1:       cur = steer_done;
        default: cur = busy;
      endcase
      if (cur == val || k >= 40) break;
    end
    checks++;
    if (cur != val) begin
      errors++;
      $display("FAIL %s timeout got=%0b exp=%0b", name, cur, val);
    end
  endtask

  // inject: 0 clean, 1 stray dst_comp[1] pulse in STEER, 2 in_comp drop in STEER
  task automatic do_word(input logic [3:0] exp_oh, input int inject, input string name);
    int         n;
    logic [3:0] want;
    n = 0;
    in_comp = 1'b1;
    sb_q.push_back(exp_oh);
    wait_sig(0, 1'b1, {name, " grant"}, n);
    want = sb_q.pop_front();
    chk({name, " steer"}, 32'(steer), 32'(want));
    chk({name, " cur_dst"}, 32'(cur_dst), 32'(oh2idx(want)));
    if (inject == 1) begin
      dst_comp = 4'b0010;
      @(negedge clk);
      n++;
      chk({name, " err_stray"}, 32'(err), 32'd1);
    end else if (inject == 2) begin
      in_comp = 1'b0;
      @(negedge clk);
      n++;
      chk({name, " hold_steer"}, 32'(steer), 32'(want));
      chk({name, " hold_done"}, 32'(steer_done), 32'd0);
      chk({name, " err_drop"}, 32'(err), 32'd1);
      in_comp = 1'b1;
    end
    dst_comp = exp_oh;
    wait_sig(1, 1'b1, {name, " ack"}, n);
    in_comp = 1'b0;
    wait_sig(0, 1'b0, {name, " release"}, n);
    dst_comp = 4'b0000;
    wait_sig(1, 1'b0, {name, " drain"}, n);
    exp_cnt = (exp_cnt + 1) & 32'hFFFF;
    chk({name, " cycles"}, 32'(n), 32'(4 + ((inject != 0) ? 1 : 0)));
    chk({name, " word_cnt"}, 32'(word_cnt), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    init_n   = 1'b0;
    in_comp  = 1'b0;
    dst_comp = 4'b0000;
    exp_cnt  = 0;
    @(negedge clk);
    @(negedge clk);
    init_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '{4'b1111, 1'b0, 4'b1111, 4'(1 << (i % 4))};
    vecs[8]  = '{4'b1010, 1'b0, 4'b1111, 4'b0010};
    vecs[9]  = '{4'b1010, 1'b0, 4'b1111, 4'b1000};
    vecs[10] = '{4'b1010, 1'b0, 4'b1111, 4'b0010};
    vecs[11] = '{4'b1010, 1'b0, 4'b1111, 4'b1000};
    vecs[12] = '{4'b1111, 1'b1, 4'b1101, 4'b0001};
    vecs[13] = '{4'b1111, 1'b1, 4'b1101, 4'b0100};
    vecs[14] = '{4'b1111, 1'b1, 4'b1101, 4'b1000};
    vecs[15] = '{4'b1111, 1'b1, 4'b1101, 4'b0001};

    // reset state
    dst_mask = 4'b1111;
    dst_rdy  = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk("rst steer", 32'(steer), 32'd0);
    chk("rst steer_done", 32'(steer_done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cur_dst", 32'(cur_dst), 32'd0);
    chk("rst word_cnt", 32'(word_cnt), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    init_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      dst_mask = vecs[i].mask;
      mode     = vecs[i].md;
      dst_rdy  = vecs[i].rdy;
      do_word(vecs[i].exp, 0, $sformatf("vec%0d", i));
      if (i == 7) begin
        chk("rot8 word_cnt", 32'(word_cnt), 32'd8);
        chk("rot8 err", 32'(err), 32'd0);
      end
    end

    // mode 0 stall at ptr=1 with dst 1 not ready
    mode     = 1'b0;
    dst_mask = 4'b1111;
    dst_rdy  = 4'b1101;
    in_comp  = 1'b1;
    repeat (6) @(negedge clk);
    chk("stall busy", 32'(busy), 32'd0);
    chk("stall steer", 32'(steer), 32'd0);
    chk("stall cur_dst", 32'(cur_dst), 32'd1);
    dst_rdy = 4'b1111;
    do_word(4'b0010, 0, "unstall");
    do_word(4'b0100, 0, "adv0");
    do_word(4'b1000, 0, "adv1");
    do_word(4'b0001, 0, "adv2");
    mode    = 1'b1;
    dst_rdy = 4'b1101;
    do_word(4'b0100, 0, "skip");
    mode    = 1'b0;
    dst_rdy = 4'b1111;

    // empty mask holds IDLE
    dst_mask = 4'b0000;
    in_comp  = 1'b1;
    repeat (6) @(negedge clk);
    chk("mask0 busy", 32'(busy), 32'd0);
    chk("mask0 steer", 32'(steer), 32'd0);
    in_comp  = 1'b0;
    dst_mask = 4'b1111;

    // sticky error from a stray completion
    do_reset();
    chk("rst2 err", 32'(err), 32'd0);
    chk("rst2 word_cnt", 32'(word_cnt), 32'd0);
    do_word(4'b0001, 1, "stray");
    do_word(4'b0010, 0, "after_stray");
    chk("sticky err", 32'(err), 32'd1);
    do_reset();
    chk("err cleared", 32'(err), 32'd0);
    do_word(4'b0001, 2, "drop");
    do_reset();

    // asynchronous reset while in ACK
    do_word(4'b0001, 0, "pre_ack");
    begin
      int n;
      n = 0;
      in_comp = 1'b1;
      wait_sig(0, 1'b1, "ackrst grant", n);
      chk("ackrst steer", 32'(steer), 32'b0010);
      dst_comp = 4'b0010;
      wait_sig(1, 1'b1, "ackrst ack", n);
    end
    #2 init_n = 1'b0;
    #1;
    chk("ackrst steer0", 32'(steer), 32'd0);
    chk("ackrst done0", 32'(steer_done), 32'd0);
    chk("ackrst busy0", 32'(busy), 32'd0);
    chk("ackrst cnt0", 32'(word_cnt), 32'd0);
    in_comp  = 1'b0;
    dst_comp = 4'b0000;
    exp_cnt  = 0;
    @(negedge clk);
    init_n = 1'b1;
    do_word(4'b0001, 0, "post_rst");

    // word counter wrap
    @(negedge clk);
    force dut.r_word_cnt = 16'hFFFF;
    #1;
    release dut.r_word_cnt;
    exp_cnt = 32'hFFFF;
    @(negedge clk);
    chk("preload cnt", 32'(word_cnt), 32'hFFFF);
    do_word(4'b0010, 0, "wrap");
    chk("wrap cnt", 32'(word_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
